// File: rtl/xbar_cmd_pkg.sv
// Shared constants for the crossbar command arbiter: default port counts,
// lane width, destination index width and contention counter width.
// The optional contention counters are built only when the macro
// XBAR_ARB_CONFLICT_CNT_EN is defined.
package xbar_cmd_pkg;

  localparam int XBAR_DATA_WIDTH = 32;
  localparam int XBAR_NUM_OUTPUT = 8;
  localparam int XBAR_NUM_INPUT  = 16;
  localparam int DW_IDX          = $clog2(XBAR_NUM_OUTPUT);
  localparam int CNT_W           = 16;

endpackage

// File: rtl/xbar_rr_arbiter.sv
// N-way round-robin arbiter for one crossbar output. The search starts at
// ptr_q and wraps; after a grant the pointer moves one past the winner.
module xbar_rr_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win;
  logic             found;

  // Pick the first requester at or above the pointer; grants are held off
  // while disabled or in reset so the pointer and grant stay consistent.
  always_comb begin
    idx     = '0;
    win     = '0;
    found   = 1'b0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + PTR_W'(i);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (en_i && found && !rst) begin
      grant_o[win] = 1'b1;
      ptr_d        = win + PTR_W'(1);
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/xbar_cmd_arbiter.sv
// Crossbar command arbiter: one round-robin arbiter per output picks at most
// one input per cycle; granted inputs are registered into one-hot routing
// commands plus payload for the downstream crossbar.
// Define XBAR_ARB_CONFLICT_CNT_EN to build per-output contention counters;
// otherwise o_conflict_cnt is tied to zero.
module xbar_cmd_arbiter
  import xbar_cmd_pkg::*;
#(
  parameter int DATA_WIDTH      = XBAR_DATA_WIDTH,
  parameter int NUM_OUTPUT_DATA = XBAR_NUM_OUTPUT,
  parameter int NUM_INPUT_DATA  = XBAR_NUM_INPUT
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_en,
  input  logic [NUM_INPUT_DATA-1:0]                        i_valid,
  input  logic [NUM_INPUT_DATA*$clog2(NUM_OUTPUT_DATA)-1:0] i_dest,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]             i_data_bus,
  output logic [NUM_INPUT_DATA-1:0]                        o_grant,
  output logic [NUM_INPUT_DATA-1:0]                        o_valid,
  output logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]             o_data_bus,
  output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]        o_cmd,
  output logic                                             o_en,
  output logic [NUM_OUTPUT_DATA*CNT_W-1:0]                 o_conflict_cnt
);

  localparam int IDX_W = $clog2(NUM_OUTPUT_DATA);

  logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] req_col;
  logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] grant_col;
  logic [NUM_INPUT_DATA-1:0]                      grant_d;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]      cmd_d;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]           data_d;

  logic [NUM_INPUT_DATA-1:0]                      valid_q;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]      cmd_q;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]           data_q;
  logic                                           en_q;

  genvar gi, gn;
  generate
    for (gi = 0; gi < NUM_OUTPUT_DATA; gi++) begin : g_out
      for (gn = 0; gn < NUM_INPUT_DATA; gn++) begin : g_in
        assign req_col[gi][gn] = i_valid[gn] &&
                                 (i_dest[gn*IDX_W +: IDX_W] == IDX_W'(gi));
        assign cmd_d[gn*NUM_OUTPUT_DATA + gi] = grant_col[gi][gn];
      end

      xbar_rr_arbiter #(
        .N (NUM_INPUT_DATA)
      ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (i_en),
        .req_i   (req_col[gi]),
        .grant_o (grant_col[gi])
      );
    end

    for (gn = 0; gn < NUM_INPUT_DATA; gn++) begin : g_lane
      assign data_d[gn*DATA_WIDTH +: DATA_WIDTH] =
        grant_d[gn] ? i_data_bus[gn*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  // An input requests exactly one output, so OR-ing the columns gives its grant.
  always_comb begin
    grant_d = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      grant_d = grant_d | grant_col[j];
    end
  end

  assign o_grant = grant_d;

  // Output stage: ungranted lanes register as zero, so disabled cycles clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      valid_q <= grant_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      en_q    <= i_en;
    end
  end

  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
  assign o_cmd      = cmd_q;
  assign o_en       = en_q;

`ifdef XBAR_ARB_CONFLICT_CNT_EN
  generate
    for (gi = 0; gi < NUM_OUTPUT_DATA; gi++) begin : g_cnt
      logic             seen_one;
      logic             seen_two;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Detect two or more requesters and advance the saturating counter.
      always_comb begin
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int n = 0; n < NUM_INPUT_DATA; n++) begin
          seen_two = seen_two | (seen_one & req_col[gi][n]);
          seen_one = seen_one | req_col[gi][n];
        end
        cnt_d = cnt_q;
        if (i_en && seen_two && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Contention counter register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign o_conflict_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_cmd_arbiter.sv
// Self-checking bench for xbar_cmd_arbiter: a behavioural round-robin model
// predicts grants and registered outputs; expectations are queued when
// stimulus is applied and compared when the DUT registers its outputs.
module tb_xbar_cmd_arbiter;
  import xbar_cmd_pkg::*;

  localparam int NI = 16;
  localparam int NO = 8;
  localparam int DW = 32;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_en = 1'b0;
  logic [NI-1:0]     i_valid = '0;
  logic [NI*IW-1:0]  i_dest = '0;
  logic [NI*DW-1:0]  i_data_bus = '0;
  logic [NI-1:0]     o_grant;
  logic [NI-1:0]     o_valid;
  logic [NI*DW-1:0]  o_data_bus;
  logic [NI*NO-1:0]  o_cmd;
  logic              o_en;
  logic [NO*16-1:0]  o_conflict_cnt;

  xbar_cmd_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (i_en),
    .i_valid        (i_valid),
    .i_dest         (i_dest),
    .i_data_bus     (i_data_bus),
    .o_grant        (o_grant),
    .o_valid        (o_valid),
    .o_data_bus     (o_data_bus),
    .o_cmd          (o_cmd),
    .o_en           (o_en),
    .o_conflict_cnt (o_conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0]    valid;
    logic [NI*DW-1:0] data;
    logic [NI*NO-1:0] cmd;
    logic             en;
  } exp_t;

  exp_t          sb_q[$];
  int            ptr_m[NO];
  int            cnt_m[NO];
  int            tests = 0;
  int            fails = 0;
  logic [NI-1:0] last_grant;

  task automatic model_reset();
    for (int j = 0; j < NO; j++) begin
      ptr_m[j] = 0;
      cnt_m[j] = 0;
    end
    sb_q.delete();
  endtask

  task automatic set_req(input int n, input int dest, input logic [DW-1:0] data);
    i_valid[n]             = 1'b1;
    i_dest[n*IW +: IW]     = IW'(dest);
    i_data_bus[n*DW +: DW] = data;
  endtask

  task automatic clear_req();
    i_valid    = '0;
    i_dest     = '0;
    i_data_bus = '0;
  endtask

  // One clock: check combinational grant, queue expected registered outputs,
  // then compare them after the edge.
  task automatic cycle(input string name);
    logic [NI-1:0]    g;
    logic [NO*16-1:0] ecnt;
    exp_t             e;
    exp_t             got;
    int               nreq[NO];
    int               win[NO];
    int               n;
    #1;
    g = '0;
    for (int j = 0; j < NO; j++) begin
      nreq[j] = 0;
      win[j]  = -1;
      for (int k = 0; k < NI; k++) begin
        if (i_valid[k] && (int'(i_dest[k*IW +: IW]) == j)) nreq[j]++;
      end
      if (i_en && !rst) begin
        for (int k = 0; k < NI; k++) begin
          n = (ptr_m[j] + k) % NI;
          if (win[j] < 0 && i_valid[n] && (int'(i_dest[n*IW +: IW]) == j)) win[j] = n;
        end
        if (win[j] >= 0) g[win[j]] = 1'b1;
      end
    end
    tests++;
    if (o_grant !== g) begin
      fails++;
      $display("FAIL %s grant: got %h expected %h", name, o_grant, g);
    end
    e.valid = g;
    e.data  = '0;
    e.cmd   = '0;
    e.en    = i_en;
    for (int k = 0; k < NI; k++) begin
      if (g[k]) begin
        e.data[k*DW +: DW] = i_data_bus[k*DW +: DW];
        e.cmd[k*NO + int'(i_dest[k*IW +: IW])] = 1'b1;
      end
    end
    sb_q.push_back(e);
    last_grant = g;
    @(posedge clk);
    #1;
    for (int j = 0; j < NO; j++) begin
      if (win[j] >= 0) ptr_m[j] = (win[j] + 1) % NI;
`ifdef XBAR_ARB_CONFLICT_CNT_EN
      if (i_en && nreq[j] >= 2 && cnt_m[j] < 65535) cnt_m[j]++;
`endif
    end
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", name);
    end else begin
      got = sb_q.pop_front();
      if (o_valid !== got.valid || o_cmd !== got.cmd || o_data_bus !== got.data || o_en !== got.en) begin
        fails++;
        $display("FAIL %s outputs: got valid=%h cmd=%h en=%b expected valid=%h cmd=%h en=%b",
                 name, o_valid, o_cmd, o_en, got.valid, got.cmd, got.en);
      end
    end
    ecnt = '0;
    for (int j = 0; j < NO; j++) ecnt[j*16 +: 16] = 16'(cnt_m[j]);
    tests++;
    if (o_conflict_cnt !== ecnt) begin
      fails++;
      $display("FAIL %s conflict_cnt: got %h expected %h", name, o_conflict_cnt, ecnt);
    end
    $display("[TB] %s grant=%h valid=%h cmd=%h", name, g, o_valid, o_cmd);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (o_valid !== '0 || o_data_bus !== '0 || o_cmd !== '0 || o_en !== 1'b0 ||
        o_grant !== '0 || o_conflict_cnt !== '0) begin
      fails++;
      $display("FAIL %s reset outputs: got valid=%h cmd=%h en=%b grant=%h cnt=%h expected all zero",
               name, o_valid, o_cmd, o_en, o_grant, o_conflict_cnt);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    i_en = 1'b1;
    set_req(1, 1, 32'h1111_1111);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    clear_req();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_single();
    i_en = 1'b1;
    set_req(3, 5, 32'hA5A5_A5A5);
    #1;
    tests++;
    if (o_grant !== 16'h0008) begin
      fails++;
      $display("FAIL single grant3: got %h expected 0008", o_grant);
    end
    cycle("single");
    tests++;
    if (o_cmd !== (128'd1 << 29) || o_data_bus[3*DW +: DW] !== 32'hA5A5_A5A5 || o_valid !== 16'h0008) begin
      fails++;
      $display("FAIL single out: got cmd=%h lane3=%h expected bit29 only and a5a5a5a5", o_cmd, o_data_bus[3*DW +: DW]);
    end
    clear_req();
    cycle("single_idle");
  endtask

  task automatic test_round_robin();
    int order[4];
    order = '{0, 4, 9, 0};
    set_req(0, 2, 32'h0000_00A0);
    set_req(4, 2, 32'h0000_00A4);
    set_req(9, 2, 32'h0000_00A9);
    for (int c = 0; c < 4; c++) begin
      cycle("rr");
      tests++;
      if (last_grant !== (16'd1 << order[c])) begin
        fails++;
        $display("FAIL rr order: got %h expected %h", last_grant, 16'd1 << order[c]);
      end
    end
  endtask

  task automatic test_enable_drop();
    i_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle("en_off");
      tests++;
      if (o_valid !== '0 || o_cmd !== '0 || o_data_bus !== '0) begin
        fails++;
        $display("FAIL en_off outputs: got valid=%h cmd=%h expected zero", o_valid, o_cmd);
      end
    end
    i_en = 1'b1;
    cycle("en_resume");
    tests++;
    if (last_grant !== 16'h0010) begin
      fails++;
      $display("FAIL en_resume pointer: got %h expected 0010", last_grant);
    end
    clear_req();
    cycle("en_idle");
  endtask

  task automatic test_all_inputs();
    logic [NI-1:0] acc;
    acc = '0;
    for (int n = 0; n < NI; n++) set_req(n, n % NO, 32'hC000_0000 | 32'(n));
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if ($countones(o_grant) != NO) begin
        fails++;
        $display("FAIL all grants_per_cycle: got %0d expected %0d", $countones(o_grant), NO);
      end
      cycle("all");
      acc = acc | last_grant;
      if (c == 1) begin
        tests++;
        if (acc !== '1) begin
          fails++;
          $display("FAIL all within_2: got %h expected ffff", acc);
        end
      end
    end
    clear_req();
    cycle("all_idle");
  endtask

  task automatic test_reset_mid();
    set_req(2, 6, 32'h0000_0B02);
    set_req(7, 6, 32'h0000_0B07);
    set_req(12, 6, 32'h0000_0B0C);
    cycle("mid_a");
    cycle("mid_b");
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    #1;
    rst = 1'b0;
    model_reset();
    cycle("mid_after");
    tests++;
    if (last_grant !== 16'h0004) begin
      fails++;
      $display("FAIL mid_after lowest: got %h expected 0004", last_grant);
    end
    clear_req();
    cycle("mid_idle");
  endtask

`ifdef XBAR_ARB_CONFLICT_CNT_EN
  task automatic test_saturation();
    set_req(0, 0, 32'h1);
    set_req(1, 0, 32'h2);
    repeat (65600) @(posedge clk);
    #1;
    tests++;
    if (o_conflict_cnt[15:0] !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturation: got %h expected ffff", o_conflict_cnt[15:0]);
    end
    clear_req();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enable_drop();
    test_all_inputs();
    test_reset_mid();
`ifdef XBAR_ARB_CONFLICT_CNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
